// File: rtl/fir_mac.sv
// fir_mac - tap-stream multiply-accumulate stage of the filter path.
//
// Consumes one burst of M taps (addresses 0..M-1 in order, gaps allowed),
// multiplies each unsigned tap by its signed Q1.(COEF_SIZE-1) coefficient,
// accumulates the burst and emits one scaled, saturated unsigned result.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-low reset
//   we          tap write strobe
//   addr        tap index of the current write
//   di          tap sample (unsigned ADC code)
//   coef_we     coefficient write strobe (honoured only while not busy)
//   coef_addr   coefficient index
//   coef_di     coefficient value (signed)
//   dout        filter result, held until the next result
//   dout_valid  one-cycle pulse when dout is updated
//   busy        high from the first accepted tap through the dout_valid cycle
//   err         one-cycle pulse on a tap protocol error
//
// Build option:
//   FIR_MAC_ROUND_EN  when defined, the accumulator is rounded half-up before
//                     the COEF_FRAC shift; otherwise the shift truncates.
module fir_mac #(
  parameter int M         = 4,
  parameter int ADDR_SIZE = 5,
  parameter int DATA_SIZE = 12,
  parameter int COEF_SIZE = 12,
  parameter int COEF_FRAC = 11,
  parameter int ACC_SIZE  = 28,
  parameter int OUT_SIZE  = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [DATA_SIZE-1:0] di,
  input  logic                 coef_we,
  input  logic [ADDR_SIZE-1:0] coef_addr,
  input  logic [COEF_SIZE-1:0] coef_di,
  output logic [OUT_SIZE-1:0]  dout,
  output logic                 dout_valid,
  output logic                 busy,
  output logic                 err
);

  localparam int PROD_SIZE = DATA_SIZE + 1 + COEF_SIZE;
  localparam int IDX_W     = (M > 1) ? $clog2(M) : 1;
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(M - 1);
  localparam logic signed [ACC_SIZE:0] SAT_MAX =
    (ACC_SIZE + 1)'((64'd1 << OUT_SIZE) - 64'd1);
`ifdef FIR_MAC_ROUND_EN
  localparam logic signed [ACC_SIZE:0] RND_HALF =
    (ACC_SIZE + 1)'(64'd1 << (COEF_FRAC - 1));
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] exp_q, exp_d;
  logic                 drain_q, drain_d;
  logic                 accept, accept_first;
  logic                 err_d, out_en;
  logic                 err_q, dout_valid_q;
  logic [OUT_SIZE-1:0]  dout_q;
  logic                 coef_wr;

  logic signed [COEF_SIZE-1:0] coef_q [M];

  logic signed [DATA_SIZE:0]   tap_p0;
  logic signed [COEF_SIZE-1:0] coef_p0;
  logic                        first_p0;
  logic                        vld_p0;
  logic signed [PROD_SIZE-1:0] prod_p1;
  logic                        first_p1;
  logic                        vld_p1;
  logic signed [ACC_SIZE-1:0]  prod_ext_p1;
  logic signed [ACC_SIZE-1:0]  acc_p2;

  // Scale the accumulator down by COEF_FRAC and clamp into the unsigned
  // output range. One guard bit keeps the rounding add from wrapping.
  function automatic logic [OUT_SIZE-1:0] scale_sat(input logic signed [ACC_SIZE-1:0] a);
    logic signed [ACC_SIZE:0] ext;
    logic signed [ACC_SIZE:0] shifted;
    logic [OUT_SIZE-1:0]      res;
    ext = (ACC_SIZE + 1)'(a);
`ifdef FIR_MAC_ROUND_EN
    ext = ext + RND_HALF;
`else
    ext = ext;
`endif
    shifted = ext >>> COEF_FRAC;
    if (shifted[ACC_SIZE]) begin
      res = '0;
    end else if (shifted > SAT_MAX) begin
      res = '1;
    end else begin
      res = shifted[OUT_SIZE-1:0];
    end
    return res;
  endfunction

  assign busy       = (state_q != S_IDLE) || dout_valid_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign err        = err_q;

  // Coefficient writes are dropped while a burst is in flight or when the
  // index is out of range, so a live burst always sees a stable table.
  assign coef_wr = coef_we && !busy && (coef_addr <= LAST_ADDR);

  always_comb begin
    state_d      = state_q;
    exp_d        = exp_q;
    drain_d      = drain_q;
    accept       = 1'b0;
    accept_first = 1'b0;
    err_d        = 1'b0;
    out_en       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (we) begin
          if (addr == '0) begin
            accept       = 1'b1;
            accept_first = 1'b1;
            exp_d        = ADDR_SIZE'(1);
            drain_d      = 1'b0;
            state_d      = (LAST_ADDR == '0) ? S_DRAIN : S_ACC;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ACC: begin
        if (we) begin
          if (addr == exp_q) begin
            accept = 1'b1;
            exp_d  = exp_q + ADDR_SIZE'(1);
            if (addr == LAST_ADDR) begin
              drain_d = 1'b0;
              state_d = S_DRAIN;
            end
          end else begin
            // Out-of-order tap aborts the burst; even addr 0 is not
            // taken as a restart, the producer has to resend it.
            err_d   = 1'b1;
            exp_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        err_d = we;
        // Two cycles let the last tap cross the product and accumulate stages.
        if (drain_q) begin
          state_d = S_OUT;
        end else begin
          drain_d = 1'b1;
        end
      end
      S_OUT: begin
        err_d   = we;
        out_en  = 1'b1;
        exp_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign prod_ext_p1 = ACC_SIZE'(prod_p1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      exp_q        <= '0;
      drain_q      <= 1'b0;
      err_q        <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
      vld_p0       <= 1'b0;
      vld_p1       <= 1'b0;
      acc_p2       <= '0;
      for (int i = 0; i < M; i++) begin
        coef_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      drain_q      <= drain_d;
      err_q        <= err_d;
      dout_valid_q <= out_en;
      if (out_en) begin
        dout_q <= scale_sat(acc_p2);
      end
      if (coef_wr) begin
        coef_q[coef_addr[IDX_W-1:0]] <= coef_di;
      end
      // stage p0 -> p1 -> p2 valid chain
      vld_p0 <= accept;
      vld_p1 <= vld_p0;
      // stage p2: accumulate (tap 0 restarts the sum)
      if (vld_p1) begin
        acc_p2 <= first_p1 ? prod_ext_p1 : acc_p2 + prod_ext_p1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // stage p0: capture tap and its coefficient
    if (accept) begin
      tap_p0   <= $signed({1'b0, di});
      coef_p0  <= coef_q[addr[IDX_W-1:0]];
      first_p0 <= accept_first;
    end
    // stage p1: product
    if (vld_p0) begin
      prod_p1  <= tap_p0 * coef_p0;
      first_p1 <= first_p0;
    end
  end

endmodule

// File: tb/tb_fir_mac.sv
module tb_fir_mac;

  localparam int M         = 4;
  localparam int ADDR_SIZE = 5;
  localparam int DATA_SIZE = 12;
  localparam int COEF_SIZE = 12;
  localparam int COEF_FRAC = 11;
  localparam int ACC_SIZE  = 28;
  localparam int OUT_SIZE  = 12;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 we = 1'b0;
  logic [ADDR_SIZE-1:0] addr = '0;
  logic [DATA_SIZE-1:0] di = '0;
  logic                 coef_we = 1'b0;
  logic [ADDR_SIZE-1:0] coef_addr = '0;
  logic [COEF_SIZE-1:0] coef_di = '0;
  logic [OUT_SIZE-1:0]  dout;
  logic                 dout_valid;
  logic                 busy;
  logic                 err;

  fir_mac #(
    .M(M), .ADDR_SIZE(ADDR_SIZE), .DATA_SIZE(DATA_SIZE), .COEF_SIZE(COEF_SIZE),
    .COEF_FRAC(COEF_FRAC), .ACC_SIZE(ACC_SIZE), .OUT_SIZE(OUT_SIZE)
  ) dut (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .di(di),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_di(coef_di),
    .dout(dout), .dout_valid(dout_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cm[M];          // model coefficient table
  int tv[M];          // taps of the next burst
  int exp_dout = 0;   // last result the model expects on dout

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: dot product, optional half-up rounding, floor shift, clamp.
  function automatic int model_out();
    longint acc;
    acc = 0;
    for (int i = 0; i < M; i++) acc += longint'(tv[i]) * longint'(cm[i]);
`ifdef FIR_MAC_ROUND_EN
    acc += longint'(1) << (COEF_FRAC - 1);
`endif
    acc = acc >>> COEF_FRAC;
    if (acc < 0) return 0;
    if (acc > (1 << OUT_SIZE) - 1) return (1 << OUT_SIZE) - 1;
    return int'(acc);
  endfunction

  task automatic load_coef(input int idx, input int val);
    coef_we   = 1'b1;
    coef_addr = ADDR_SIZE'(idx);
    coef_di   = COEF_SIZE'(val);
    tick();
    coef_we   = 1'b0;
  endtask

  task automatic set_all_coefs(input int val);
    for (int i = 0; i < M; i++) begin
      load_coef(i, val);
      cm[i] = val;
    end
  endtask

  task automatic send_tap(input int a, input int d);
    we   = 1'b1;
    addr = ADDR_SIZE'(a);
    di   = DATA_SIZE'(d);
    tick();
    we   = 1'b0;
  endtask

  // Sends taps tv[0..M-1] in order with random gaps, then checks latency,
  // value and busy. busy_coef_idx >= 0 issues a coefficient write of 0 to
  // that index right after tap 0 (must be ignored).
  task automatic do_burst(input int gap_max, input bit chk_idle, input int busy_coef_idx);
    int lat;
    for (int i = 0; i < M; i++) begin
      if (i > 0) repeat ($urandom_range(0, gap_max)) tick();
      send_tap(i, tv[i]);
      if (i == 0 && busy_coef_idx >= 0) load_coef(busy_coef_idx, 0);
    end
    exp_dout = model_out();
    lat = 0;
    while (lat < 8) begin
      tick();
      lat++;
      if (dout_valid) break;
    end
    n_checks++;
    if (lat !== 3 || dout_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL burst_latency: got %0d cycles (valid=%b) expected 3", lat, dout_valid);
    end
    n_checks++;
    if (dout !== OUT_SIZE'(exp_dout)) begin
      n_fail++;
      $display("FAIL burst_dout: got %0d expected %0d", dout, exp_dout);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_on_valid: got %b expected 1", busy);
    end
    if (chk_idle) begin
      tick();
      n_checks++;
      if (busy !== 1'b0 || dout_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL after_valid: busy=%b dout_valid=%b expected 0/0", busy, dout_valid);
      end
    end
  endtask

  task automatic expect_quiet(input int cycles, input int held, input string name);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (dout_valid) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL %s_no_valid: got %0d pulses expected 0", name, pulses);
    end
    n_checks++;
    if (dout !== OUT_SIZE'(held)) begin
      n_fail++;
      $display("FAIL %s_dout_held: got %0d expected %0d", name, dout, held);
    end
  endtask

  task automatic set_taps(input int a, input int b, input int c, input int d);
    tv[0] = a; tv[1] = b; tv[2] = c; tv[3] = d;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < M; i++) cm[i] = 0;
    n_checks++;
    if (dout !== '0) begin n_fail++; $display("FAIL reset_dout: got %0d expected 0", dout); end
    n_checks++;
    if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", dout_valid); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    rst = 1'b1;
    tick();
    // Coefficients come out of reset as zero.
    set_taps(4095, 3000, 2000, 1000);
    do_burst(0, 1, -1);
  endtask

  task automatic test_basic();
    set_all_coefs(512);
    set_taps(100, 200, 300, 400);
    do_burst(0, 1, -1);
  endtask

  task automatic test_rounding();
    set_all_coefs(0);
    load_coef(0, 1);
    cm[0] = 1;
    set_taps(1024, $urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095));
    do_burst(0, 1, -1);
  endtask

  task automatic test_saturation();
    set_all_coefs(2047);
    set_taps(4095, 4095, 4095, 4095);
    do_burst(1, 1, -1);
    set_all_coefs(-2048);
    set_taps(100, 100, 100, 100);
    do_burst(1, 1, -1);
  endtask

  task automatic test_idle_err();
    send_tap(2, 123);
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_bad_addr: err=%b busy=%b expected 1/0", err, busy);
    end
    tick();
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL idle_err_width: got %b expected 0", err); end
  endtask

  task automatic test_abort();
    set_all_coefs(512);
    set_taps(40, 80, 120, 160);
    do_burst(0, 1, -1);
    send_tap(0, 4000);
    send_tap(1, 4000);
    send_tap(3, 4000);
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL abort_err: got %b expected 1", err); end
    tick();
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL abort_err_width: got %b expected 0", err); end
    expect_quiet(6, exp_dout, "abort");
    set_taps(100, 200, 300, 400);
    do_burst(0, 1, -1);
  endtask

  task automatic test_gaps();
    set_all_coefs(512);
    set_taps(100, 200, 300, 400);
    for (int k = 0; k < 4; k++) do_burst(5, 1, -1);
  endtask

  task automatic test_reset_midburst();
    set_all_coefs(512);
    send_tap(0, 900);
    send_tap(1, 900);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < M; i++) cm[i] = 0;
    exp_dout = 0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    expect_quiet(6, 0, "midreset");
    set_all_coefs(512);
    set_taps(100, 200, 300, 400);
    do_burst(0, 1, -1);
  endtask

  task automatic test_coef_guard();
    set_all_coefs(512);
    set_taps(100, 200, 300, 400);
    do_burst(0, 1, 1);     // write during busy must be dropped
    load_coef(5, 0);       // out-of-range index must be dropped
    do_burst(2, 1, -1);
  endtask

  task automatic test_back_to_back();
    set_all_coefs(300);
    set_taps(1000, 2000, 3000, 4000);
    do_burst(0, 0, -1);
    set_taps(10, 20, 30, 40);
    do_burst(0, 1, -1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < M; i++) begin
        int r;
        r = int'($urandom_range(0, 4095));
        if (r >= 2048) r -= 4096;
        load_coef(i, r);
        cm[i] = r;
        tv[i] = int'($urandom_range(0, 4095));
      end
      do_burst(3, 1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_idle_err();
    test_abort();
    test_gaps();
    test_reset_midburst();
    test_coef_guard();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
